// File: rtl/text_console_pkg.sv
// Shared constants, control codes and sequencer states
// for the text console controller.
package text_console_pkg;

  localparam logic [7:0] OFF_CTRL = 8'd0;
  localparam logic [7:0] OFF_CX   = 8'd1;
  localparam logic [7:0] OFF_CY   = 8'd2;
  localparam logic [7:0] OFF_ATTR = 8'd3;
  localparam logic [7:0] OFF_CHAR = 8'd4;
  localparam logic [7:0] OFF_PHI  = 8'd6;
  localparam logic [7:0] OFF_PLO  = 8'd7;
  localparam logic [7:0] OFF_DATA = 8'd8;

  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_TAB   = 8'h09;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_ESC   = 8'h1B;
  localparam logic [7:0] CMD_CLR  = 8'h01;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [4:0] {
    S_INIT_ATTR,
    S_INIT_CLR,
    S_IDLE,
    S_DECODE,
    S_WR_X,
    S_WR_Y,
    S_WR_CH,
    S_FF,
    S_ESC_WAIT,
    S_ESC_WR,
    S_SR_HI,
    S_SR_LO,
    S_SR_RD,
    S_SW_HI,
    S_SW_LO,
    S_SW_WR,
    S_BL_HI,
    S_BL_LO,
    S_BL_WR
  } state_t;

  function automatic logic is_print(
    input logic [7:0] b
  );
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Stream input and Wishbone master bundle
// of the text console controller.
interface text_console_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic       wb_ack_i;

  modport master (
    input  in_data, in_valid,
    input  wb_dat_i, wb_ack_i,
    output in_ready,
    output wb_adr_o, wb_dat_o,
    output wb_cyc_o, wb_stb_o, wb_we_o
  );

  modport slave (
    output in_data, in_valid,
    output wb_dat_i, wb_ack_i,
    input  in_ready,
    input  wb_adr_o, wb_dat_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o
  );
endinterface

// File: rtl/text_console_ctrl_wb_byte_master.sv
// Single-transaction Wishbone byte master; a new
// request is only taken while cyc is low.
module wb_byte_master (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] adr,
  input  logic [7:0] dat,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  // cyc drops on the edge after ack, so the next
  // request sees one idle cycle before it starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      rdata    <= '0;
    end else if (wb_cyc_o) begin
      if (wb_ack_i) begin
        wb_cyc_o <= 1'b0;
        if (!wb_we_o) rdata <= wb_dat_i;
      end
    end else if (req) begin
      wb_adr_o <= adr;
      wb_dat_o <= dat;
      wb_we_o  <= we;
      wb_cyc_o <= 1'b1;
    end
  end

  assign wb_stb_o = wb_cyc_o;
  assign done     = wb_cyc_o & wb_ack_i;

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal sequencer: byte stream in, char-RAM
// Wishbone writes out, with cursor and scroll.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter logic [7:0] BASE_ADDR = 8'h20,
  parameter logic [7:0] INIT_ATTR = 8'h07,
  parameter int         TAB_W     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  text_console_if.master bus,
  output logic          busy,
  output logic [6:0]    cur_col,
  output logic [4:0]    cur_row
);

  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [11:0] SCR_LAST = 12'(COLS * (ROWS - 1) - 1);
  localparam logic [11:0] BL_BASE  = 12'(COLS * (ROWS - 1));
  localparam logic [11:0] BL_LAST  = 12'(COLS - 1);
  localparam logic [7:0]  TAB_MSK  = 8'(TAB_W - 1);

  state_t      state, nstate;
  logic [7:0]  byte_q;
  logic [11:0] idx;
  logic [11:0] src;
  logic [7:0]  tab_nx;
  logic [6:0]  tab_col;
  logic        bottom;
  logic        accept;
  logic        in_rdy;
  logic        req, we, done;
  logic [7:0]  off, dat, rdata;

  assign src     = idx + 12'(COLS);
  assign tab_nx  = ({1'b0, cur_col} | TAB_MSK) + 8'd1;
  assign tab_col = (tab_nx > {1'b0, COL_LAST}) ?
                   COL_LAST : tab_nx[6:0];
  assign bottom  = (cur_row == ROW_LAST);
  assign accept  = bus.in_valid & in_rdy;
  assign bus.in_ready = in_rdy;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT_ATTR;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_INIT_ATTR: if (done) nstate = S_INIT_CLR;
      S_INIT_CLR:  if (done) nstate = S_IDLE;
      S_IDLE:      if (accept) nstate = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_print(byte_q): nstate = S_WR_X;
          byte_q == CC_LF:
            nstate = bottom ? S_SR_HI : S_IDLE;
          byte_q == CC_FF:  nstate = S_FF;
          byte_q == CC_ESC: nstate = S_ESC_WAIT;
          default:          nstate = S_IDLE;
        endcase
      end
      S_WR_X: if (done) nstate = S_WR_Y;
      S_WR_Y: if (done) nstate = S_WR_CH;
      S_WR_CH:
        if (done)
          nstate = (cur_col == COL_LAST && bottom) ?
                   S_SR_HI : S_IDLE;
      S_FF:       if (done) nstate = S_IDLE;
      S_ESC_WAIT: if (accept) nstate = S_ESC_WR;
      S_ESC_WR:   if (done) nstate = S_IDLE;
      S_SR_HI:    if (done) nstate = S_SR_LO;
      S_SR_LO:    if (done) nstate = S_SR_RD;
      S_SR_RD:    if (done) nstate = S_SW_HI;
      S_SW_HI:    if (done) nstate = S_SW_LO;
      S_SW_LO:    if (done) nstate = S_SW_WR;
      S_SW_WR:
        if (done)
          nstate = (idx == SCR_LAST) ? S_BL_HI : S_SR_HI;
      S_BL_HI:    if (done) nstate = S_BL_LO;
      S_BL_LO:    if (done) nstate = S_BL_WR;
      S_BL_WR:
        if (done)
          nstate = (idx == BL_LAST) ? S_IDLE : S_BL_WR;
      default:    nstate = S_INIT_ATTR;
    endcase
  end

  always_comb begin
    req    = 1'b0;
    we     = 1'b1;
    off    = OFF_CTRL;
    dat    = 8'h00;
    in_rdy = 1'b0;
    unique case (state)
      S_INIT_ATTR: begin
        req = 1'b1; off = OFF_ATTR; dat = INIT_ATTR;
      end
      S_INIT_CLR, S_FF: begin
        req = 1'b1; off = OFF_CTRL; dat = CMD_CLR;
      end
      S_IDLE, S_ESC_WAIT: in_rdy = 1'b1;
      S_WR_X: begin
        req = 1'b1; off = OFF_CX; dat = {1'b0, cur_col};
      end
      S_WR_Y: begin
        req = 1'b1; off = OFF_CY; dat = {3'b0, cur_row};
      end
      S_WR_CH: begin
        req = 1'b1; off = OFF_CHAR; dat = byte_q;
      end
      S_ESC_WR: begin
        req = 1'b1; off = OFF_ATTR; dat = byte_q;
      end
      S_SR_HI: begin
        req = 1'b1; off = OFF_PHI; dat = {4'h0, src[11:8]};
      end
      S_SR_LO: begin
        req = 1'b1; off = OFF_PLO; dat = src[7:0];
      end
      S_SR_RD: begin
        req = 1'b1; we = 1'b0; off = OFF_DATA;
      end
      S_SW_HI: begin
        req = 1'b1; off = OFF_PHI; dat = {4'h0, idx[11:8]};
      end
      S_SW_LO: begin
        req = 1'b1; off = OFF_PLO; dat = idx[7:0];
      end
      S_SW_WR: begin
        req = 1'b1; off = OFF_DATA; dat = rdata;
      end
      S_BL_HI: begin
        req = 1'b1; off = OFF_PHI;
        dat = {4'h0, BL_BASE[11:8]};
      end
      S_BL_LO: begin
        req = 1'b1; off = OFF_PLO; dat = BL_BASE[7:0];
      end
      S_BL_WR: begin
        req = 1'b1; off = OFF_DATA; dat = CH_SPACE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q  <= '0;
      idx     <= '0;
      cur_col <= '0;
      cur_row <= '0;
    end else begin
      if (accept) byte_q <= bus.in_data;
      unique case (state)
        S_INIT_CLR, S_FF:
          if (done) begin
            cur_col <= '0;
            cur_row <= '0;
          end
        S_DECODE: begin
          idx <= '0;
          unique case (1'b1)
            byte_q == CC_CR:  cur_col <= '0;
            byte_q == CC_LF:
              if (!bottom) cur_row <= cur_row + 5'd1;
            byte_q == CC_BS:
              if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
            byte_q == CC_TAB: cur_col <= tab_col;
            default: ;
          endcase
        end
        S_WR_CH:
          if (done) begin
            if (cur_col == COL_LAST) begin
              cur_col <= '0;
              if (!bottom) cur_row <= cur_row + 5'd1;
            end else begin
              cur_col <= cur_col + 7'd1;
            end
          end
        S_SW_WR:
          if (done) idx <= (idx == SCR_LAST) ? '0 : idx + 12'd1;
        S_BL_WR:
          if (done) idx <= idx + 12'd1;
        default: ;
      endcase
    end
  end

  wb_byte_master u_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .adr      (BASE_ADDR + off),
    .dat      (dat),
    .done     (done),
    .rdata    (rdata),
    .wb_adr_o (bus.wb_adr_o),
    .wb_dat_o (bus.wb_dat_o),
    .wb_cyc_o (bus.wb_cyc_o),
    .wb_stb_o (bus.wb_stb_o),
    .wb_we_o  (bus.wb_we_o),
    .wb_dat_i (bus.wb_dat_i),
    .wb_ack_i (bus.wb_ack_i)
  );

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl with a
// char-RAM slave model and write log.
module tb_text_console_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  int         checks = 0;
  int         errors = 0;

  text_console_if bus ();

  always #5 clk = ~clk;

  text_console_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .cur_col (cur_col),
    .cur_row (cur_row)
  );

  logic [7:0]  ram [0:4095];
  logic [7:0]  s_cx, s_cy, s_attr;
  logic [11:0] s_ptr;
  logic        fill_pat = 1'b0;
  logic [15:0] wlog [$];
  wire  [7:0]  s_off = bus.wb_adr_o - 8'h20;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7) ^ (i / 80));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_ack_i <= 1'b0;
    end else begin
      bus.wb_ack_i <= 1'b0;
      if (fill_pat)
        for (int i = 0; i < 2400; i++) ram[i] <= pat(i);
      if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i) begin
        bus.wb_ack_i <= 1'b1;
        if (bus.wb_we_o) begin
          wlog.push_back({bus.wb_adr_o, bus.wb_dat_o});
          case (s_off)
            8'd0: if (bus.wb_dat_o == 8'h01)
              for (int i = 0; i < 2400; i++) ram[i] <= 8'h20;
            8'd1: s_cx <= bus.wb_dat_o;
            8'd2: s_cy <= bus.wb_dat_o;
            8'd3: s_attr <= bus.wb_dat_o;
            8'd4: ram[int'(s_cy) * 80 + int'(s_cx)] <= bus.wb_dat_o;
            8'd6: s_ptr[11:8] <= bus.wb_dat_o[3:0];
            8'd7: s_ptr[7:0] <= bus.wb_dat_o;
            8'd8: begin
              ram[s_ptr] <= bus.wb_dat_o;
              s_ptr <= s_ptr + 12'd1;
            end
            default: ;
          endcase
        end else if (s_off == 8'd8) begin
          bus.wb_dat_i <= ram[s_ptr];
          s_ptr <= s_ptr + 12'd1;
        end
      end
    end
  end

  task automatic wait_ready(input int max);
    int n = 0;
    while (!bus.in_ready && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1",
               bus.in_ready, n);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit wait_done);
    wait_ready(200);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (wait_done) begin
      @(negedge clk);
      wait_ready(200);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.in_ready, busy}
        !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctl: cyc/stb/we/rdy/busy=%b required 00001",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                bus.in_ready, busy});
    end
    checks++;
    if ({bus.wb_adr_o, bus.wb_dat_o, cur_col, cur_row} !== 28'd0) begin
      errors++;
      $display("FAIL reset_val: adr=%h dat=%h col=%0d row=%0d required 0",
               bus.wb_adr_o, bus.wb_dat_o, cur_col, cur_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(100);
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 16'h2307 ||
        wlog[1] !== 16'h2001) begin
      errors++;
      $display("FAIL init_seq: n=%0d w0=%h w1=%h required 2 2307 2001",
               wlog.size(), wlog[0], wlog[1]);
    end
    checks++;
    if ({cur_col, cur_row, bus.in_ready} !== 13'd1) begin
      errors++;
      $display("FAIL init_cur: col=%0d row=%0d rdy=%b required 0 0 1",
               cur_col, cur_row, bus.in_ready);
    end
  endtask

  task automatic test_ab;
    logic [15:0] exp [6];
    int n0;
    exp = '{16'h2100, 16'h2200, 16'h2441,
            16'h2101, 16'h2200, 16'h2442};
    n0 = wlog.size();
    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wlog[n0 + i] !== exp[i]) begin
        errors++;
        $display("FAIL ab_wr%0d: got %h required %h",
                 i, wlog[n0 + i], exp[i]);
      end
    end
    checks++;
    if (cur_col !== 7'd2) begin
      errors++;
      $display("FAIL ab_col: got %0d required 2", cur_col);
    end
  endtask

  task automatic test_wrap;
    int n0;
    send(8'h0D, 1'b1);
    n0 = wlog.size();
    for (int i = 0; i < 80; i++) send(8'h78, 1'b1);
    checks++;
    if (wlog.size() != n0 + 240) begin
      errors++;
      $display("FAIL wrap_cnt: got %0d required %0d",
               wlog.size() - n0, 240);
    end
    checks++;
    if (wlog[n0 + 237] !== 16'h214F || wlog[n0 + 238] !== 16'h2200 ||
        wlog[n0 + 239] !== 16'h2478) begin
      errors++;
      $display("FAIL wrap_last: got %h %h %h required 214f 2200 2478",
               wlog[n0 + 237], wlog[n0 + 238], wlog[n0 + 239]);
    end
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd1 || ram[79] !== 8'h78) begin
      errors++;
      $display("FAIL wrap_cur: col=%0d row=%0d ram79=%h required 0 1 78",
               cur_col, cur_row, ram[79]);
    end
  endtask

  task automatic test_ctrl_codes;
    logic [7:0] seq [4];
    logic [6:0] exp [4];
    int n0;
    seq = '{8'h0D, 8'h09, 8'h09, 8'h08};
    exp = '{7'd0, 7'd8, 7'd16, 7'd15};
    for (int i = 0; i < 5; i++) send(8'h79, 1'b1);
    checks++;
    if (cur_col !== 7'd5) begin
      errors++;
      $display("FAIL ctl_pre: col=%0d required 5", cur_col);
    end
    n0 = wlog.size();
    for (int i = 0; i < 4; i++) begin
      send(seq[i], 1'b1);
      checks++;
      if (cur_col !== exp[i]) begin
        errors++;
        $display("FAIL ctl_col%0d: got %0d required %0d",
                 i, cur_col, exp[i]);
      end
    end
    for (int i = 0; i < 8; i++) send(8'h09, 1'b1);
    checks++;
    if (cur_col !== 7'd72) begin
      errors++;
      $display("FAIL tab72: got %0d required 72", cur_col);
    end
    send(8'h09, 1'b1);
    checks++;
    if (cur_col !== 7'd79) begin
      errors++;
      $display("FAIL tab_clamp: got %0d required 79", cur_col);
    end
    send(8'h09, 1'b1);
    send(8'h0D, 1'b1);
    send(8'h08, 1'b1);
    send(8'h01, 1'b1);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd1) begin
      errors++;
      $display("FAIL bs_zero: col=%0d row=%0d required 0 1",
               cur_col, cur_row);
    end
    checks++;
    if (wlog.size() != n0) begin
      errors++;
      $display("FAIL ctl_nobus: got %0d writes required 0",
               wlog.size() - n0);
    end
  endtask

  task automatic test_ff;
    send(8'h0C, 1'b1);
    checks++;
    if (wlog[$] !== 16'h2001 || cur_col !== 7'd0 ||
        cur_row !== 5'd0) begin
      errors++;
      $display("FAIL ff: wr=%h col=%0d row=%0d required 2001 0 0",
               wlog[$], cur_col, cur_row);
    end
  endtask

  task automatic test_scroll;
    int n0, bad, viol, cyc;
    for (int i = 0; i < 29; i++) send(8'h0A, 1'b1);
    checks++;
    if (cur_row !== 5'd29) begin
      errors++;
      $display("FAIL lf_row: got %0d required 29", cur_row);
    end
    fill_pat = 1'b1;
    @(negedge clk);
    fill_pat = 1'b0;
    n0 = wlog.size();
    send(8'h0A, 1'b0);
    viol = 0;
    cyc = 0;
    @(negedge clk);
    while (!bus.in_ready && cyc < 60000) begin
      if (!busy) viol++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!bus.in_ready || viol != 0) begin
      errors++;
      $display("FAIL scroll_busy: rdy=%b viol=%0d required 1 0",
               bus.in_ready, viol);
    end
    checks++;
    if (wlog.size() != n0 + 11682) begin
      errors++;
      $display("FAIL scroll_cnt: got %0d required 11682",
               wlog.size() - n0);
    end
    bad = 0;
    for (int i = 0; i < 2320; i++)
      if (ram[i] !== pat(i + 80)) bad++;
    for (int i = 2320; i < 2400; i++)
      if (ram[i] !== 8'h20) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL scroll_ram: %0d bad bytes required 0", bad);
    end
    checks++;
    if (cur_row !== 5'd29 || cur_col !== 7'd0) begin
      errors++;
      $display("FAIL scroll_cur: col=%0d row=%0d required 0 29",
               cur_col, cur_row);
    end
  endtask

  task automatic test_esc;
    int n0;
    n0 = wlog.size();
    send(8'h1B, 1'b1);
    send(8'h1F, 1'b1);
    checks++;
    if (wlog.size() != n0 + 1 || wlog[$] !== 16'h231F ||
        s_attr !== 8'h1F || cur_col !== 7'd0) begin
      errors++;
      $display("FAIL esc_attr: n=%0d wr=%h col=%0d required 1 231f 0",
               wlog.size() - n0, wlog[$], cur_col);
    end
    send(8'h5A, 1'b1);
    checks++;
    if (wlog[$] !== 16'h245A || cur_col !== 7'd1 ||
        ram[29 * 80] !== 8'h5A) begin
      errors++;
      $display("FAIL esc_z: wr=%h col=%0d ram=%h required 245a 1 5a",
               wlog[$], cur_col, ram[29 * 80]);
    end
  endtask

  task automatic test_reset_mid_scroll;
    int n;
    send(8'h0A, 1'b0);
    repeat (300) @(negedge clk);
    n = 0;
    while (!bus.wb_cyc_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.wb_cyc_o || !busy) begin
      errors++;
      $display("FAIL mid_busy: cyc=%b busy=%b required 1 1",
               bus.wb_cyc_o, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: cyc=%b stb=%b required 0 0",
               bus.wb_cyc_o, bus.wb_stb_o);
    end
    wlog.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(100);
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 16'h2307 ||
        wlog[1] !== 16'h2001 || cur_col !== 7'd0 ||
        cur_row !== 5'd0) begin
      errors++;
      $display("FAIL reinit: n=%0d w0=%h w1=%h col=%0d row=%0d",
               wlog.size(), wlog[0], wlog[1], cur_col, cur_row);
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.wb_dat_i = 8'h00;
    test_reset();
    test_ab();
    test_wrap();
    test_ctrl_codes();
    test_ff();
    test_scroll();
    test_esc();
    test_reset_mid_scroll();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
